// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and default timing constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_state_e;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_PKT_LEN    = 13;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;
    // Two-stage capture; both stages reset to the line's idle level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with valid/ack output buffer and packet index
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PKT_LEN    = UART_PKT_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic [3:0] char_index,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);
    localparam int            TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    IDX_LAST = 4'(PKT_LEN - 1);

    uart_state_e   r_state;
    logic [TW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic [3:0]    r_index;
    logic [3:0]    r_next_index;
    logic          r_valid;
    logic          r_framing_err;
    logic          r_overrun;
    logic          w_rx_s;
    logic          w_tick_end;
    logic          w_good;
    logic          w_load;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    assign w_tick_end = r_tick == TICK_END;
    assign w_good     = (r_state == STOP) && w_tick_end && w_rx_s;
    assign w_load     = w_good && (!r_valid || data_ack);

    // Frame FSM: qualify start bit at mid-bit, sample data bits mid-bit LSB first, check stop bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_tick        <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_framing_err <= 1'b0;
        end else begin
            r_framing_err <= 1'b0;
            r_tick        <= w_tick_end ? '0 : r_tick + 1'b1;
            case (r_state)
                IDLE: begin
                    r_tick <= '0;
                    if (!w_rx_s) r_state <= START;
                end
                START: if (r_tick == TICK_MID) begin
                    r_tick  <= '0;
                    r_bit   <= '0;
                    r_state <= w_rx_s ? IDLE : DATA;
                end
                DATA: if (w_tick_end) begin
                    r_shift <= {w_rx_s, r_shift[7:1]};
                    r_bit   <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_state <= STOP;
                end
                STOP: if (w_tick_end) begin
                    r_state       <= w_rx_s ? IDLE : WAIT_HIGH;
                    r_framing_err <= !w_rx_s;
                end
                WAIT_HIGH: if (w_rx_s) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output buffer: load good characters when free or being acked, else drop with overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data       <= '0;
            r_index      <= '0;
            r_next_index <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_good && !w_load;
            if (w_load) begin
                r_data       <= r_shift;
                r_index      <= r_next_index;
                r_next_index <= (r_next_index == IDX_LAST) ? '0 : r_next_index + 1'b1;
                r_valid      <= 1'b1;
            end else if (data_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data        = r_data;
    assign data_valid  = r_valid;
    assign char_index  = r_index;
    assign framing_err = r_framing_err;
    assign overrun     = r_overrun;
    assign busy        = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at OVERSAMPLE=16, PKT_LEN=13
module tb_uart_rx;
    localparam int OS = 16;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       rx        = 1'b1;
    logic       ack_man   = 1'b0;
    logic       ack_auto  = 1'b0;
    logic       auto_mode = 1'b0;
    logic       pv        = 1'b0;
    logic       pa        = 1'b0;
    logic       data_ack;
    logic [7:0] data;
    logic [3:0] char_index;
    logic       data_valid, framing_err, overrun, busy;
    int n_chk = 0, n_err = 0;
    int cyc = 0, fall_cyc = 0, rise_cyc = -1;
    int fe_cnt = 0, ov_cnt = 0, ld_cnt = 0;
    logic [11:0] exp_q[$];

    assign data_ack = ack_man | ack_auto;

    uart_rx #(.OVERSAMPLE(OS), .PKT_LEN(13)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .data        (data),
        .data_valid  (data_valid),
        .data_ack    (data_ack),
        .char_index  (char_index),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        fall_cyc = cyc;
        tick(OS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(OS);
        end
        rx = stop;
        tick(OS);
    endtask

    // Monitor: count pulses, detect loads (rise, or still valid after an ack) and score them
    always @(negedge clk) begin : mon
        logic [11:0] e;
        if (framing_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (data_valid && (!pv || pa)) begin
            ld_cnt++;
            if (!pv) rise_cyc = cyc;
            check("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rx_data", 32'(data), 32'(e[11:4]));
                check("rx_index", 32'(char_index), 32'(e[3:0]));
            end
        end
        ack_auto = auto_mode && data_valid && !pv;
        pv = data_valid;
        pa = ack_man | ack_auto;
    end

    initial begin
        int lat, fe0, ov0, ld0;
        tick(3);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_index", 32'(char_index), 0);
        check("rst_fe", 32'(framing_err), 0);
        check("rst_ov", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick(5);
        // single good frame, latency window
        exp_q.push_back({8'hA5, 4'd0});
        send_frame(8'hA5, 1'b1);
        tick(20);
        lat = rise_cyc - fall_cyc;
        check("a5_latency_ok", 32'(lat >= 153 && lat <= 156), 1);
        check("a5_valid", 32'(data_valid), 1);
        check("a5_fe", fe_cnt, 0);
        check("a5_sb_drain", exp_q.size(), 0);
        ack_man = 1'b1; tick(1); ack_man = 1'b0; tick(1);
        check("a5_ack_clears", 32'(data_valid), 0);
        ack_man = 1'b1; tick(1); ack_man = 1'b0; tick(1);
        check("idle_ack_ignored", 32'(data_valid), 0);
        // short low glitch is rejected silently
        fe0 = fe_cnt; ov0 = ov_cnt; ld0 = ld_cnt;
        rx = 1'b0; tick(4); rx = 1'b1; tick(40);
        check("glitch_valid", 32'(data_valid), 0);
        check("glitch_busy", 32'(busy), 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_ov", ov_cnt - ov0, 0);
        check("glitch_loads", ld_cnt - ld0, 0);
        // bad stop bit followed by a held break
        do_reset();
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        tick(100);
        check("brk_fe_pulses", fe_cnt - fe0, 1);
        check("brk_busy_held", 32'(busy), 1);
        check("brk_valid", 32'(data_valid), 0);
        rx = 1'b1;
        tick(4);
        check("brk_busy_released", 32'(busy), 0);
        exp_q.push_back({8'h7E, 4'd0});
        send_frame(8'h7E, 1'b1);
        tick(20);
        check("brk_next_sb_drain", exp_q.size(), 0);
        // back-to-back frames without ack: second one overruns
        do_reset();
        ov0 = ov_cnt;
        exp_q.push_back({8'h11, 4'd0});
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(20);
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_data_held", 32'(data), 32'h11);
        check("ovr_index_held", 32'(char_index), 0);
        check("ovr_valid", 32'(data_valid), 1);
        check("ovr_sb_drain", exp_q.size(), 0);
        // fourteen frames acked on rise: index wraps 12 -> 0
        do_reset();
        ov0 = ov_cnt;
        auto_mode = 1'b1;
        for (int k = 0; k < 14; k++) begin
            exp_q.push_back({8'(k * 7 + 3), 4'(k % 13)});
            send_frame(8'(k * 7 + 3), 1'b1);
        end
        tick(20);
        auto_mode = 1'b0;
        check("seq_sb_drain", exp_q.size(), 0);
        check("seq_valid", 32'(data_valid), 0);
        check("seq_ov", ov_cnt - ov0, 0);
        // ack landing on the same edge as the next load
        do_reset();
        ov0 = ov_cnt;
        exp_q.push_back({8'h81, 4'd0});
        send_frame(8'h81, 1'b1);
        exp_q.push_back({8'h42, 4'd1});
        fork
            send_frame(8'h42, 1'b1);
            begin
                tick(lat - 1);
                ack_man = 1'b1;
                tick(1);
                ack_man = 1'b0;
            end
        join
        tick(5);
        check("co_valid", 32'(data_valid), 1);
        check("co_data", 32'(data), 32'h42);
        check("co_index", 32'(char_index), 1);
        check("co_ov", ov_cnt - ov0, 0);
        check("co_sb_drain", exp_q.size(), 0);
        // reset in the middle of a frame, then a clean frame
        do_reset();
        fe0 = fe_cnt; ov0 = ov_cnt; ld0 = ld_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(60);
                reset = 1'b1;
                tick(2);
                reset = 1'b0;
            end
        join
        exp_q.push_back({8'h5A, 4'd0});
        send_frame(8'h5A, 1'b1);
        tick(20);
        check("mrst_loads", ld_cnt - ld0, 1);
        check("mrst_fe", fe_cnt - fe0, 0);
        check("mrst_ov", ov_cnt - ov0, 0);
        check("mrst_data", 32'(data), 32'h5A);
        check("mrst_index", 32'(char_index), 0);
        check("mrst_sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
